// File: rtl/load_store_unit_if.sv
// Processor request/response and word-memory bus bundle for the load/store unit.
// slave = the LSU itself, master = the processor/memory environment that drives it.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word processor accesses onto a 32-bit word memory bus.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of truncating the address.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    alo_q, alo_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic [7:0]    rd_lane [4];
    logic [3:0]    req_be;
    logic [31:0]   req_rep;
    logic          req_trap;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    // Per-lane byte enable and store replication; a misaligned half uses addr[1] only.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
            assign req_be[gi]  = (bus.req_size == 2'b10) ||
                                 (bus.req_size == 2'b01 && bus.req_addr[1] == 1'(gi / 2)) ||
                                 (bus.req_size == 2'b00 && bus.req_addr[1:0] == 2'(gi));
            assign req_rep[8*gi +: 8] = (bus.req_size == 2'b00) ? bus.req_wdata[7:0] :
                                        (bus.req_size == 2'b01) ? bus.req_wdata[8*(gi%2) +: 8] :
                                                                  bus.req_wdata[8*gi +: 8];
        end
    endgenerate

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_trap = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    assign req_trap = (bus.req_size == 2'b11);
`endif

    assign ld_byte = rd_lane[alo_q];
    assign ld_half = alo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_ext = bus.mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // mem_addr_q / mem_wdata_q double as the latched address and store data.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        alo_d        = alo_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'd0;
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 32'd0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d   = bus.req_we;
                    size_d = bus.req_size;
                    uns_d  = bus.req_unsigned;
                    alo_d  = bus.req_addr[1:0];
                    cnt_d  = '0;
                    if (req_trap) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_be_d    = req_be;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = req_rep;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'd0 : load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_be_d    = mem_be_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            alo_q        <= 2'b00;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            alo_q        <= alo_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Ready is masked by rst so it is low while reset is held and high the cycle it drops.
    assign bus.req_ready  = (state_q == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL be clocked by one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 16: the maximum number of ACCESS cycles to wait for mem_ack before an error response.
REQ-003 Ports, processor side (direction, width, meaning), SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
REQ-004 Ports, memory side, SHALL be:
- mem_en  out  1  access strobe.
- mem_we  out  1  write.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address, bits[1:0] = 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word.
- mem_ack  in  1  access complete.

Function
REQ-005 The FSM SHALL have states IDLE, ACCESS and DONE; req_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE with req_valid=1, the block SHALL latch all req_* fields and go to ACCESS on the next edge; with req_valid=0 it SHALL stay in IDLE.
REQ-007 In ACCESS, mem_en, mem_we, mem_be, mem_addr and mem_wdata SHALL be driven from the latched request and held stable until mem_ack or timeout.
REQ-008 mem_ack=1 in ACCESS SHALL capture mem_rdata and move to DONE; minimum latency is accept at cycle N, mem_en at N+1, resp_valid at N+2.
REQ-009 DONE SHALL assert resp_valid for exactly one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after DONE.
REQ-010 Byte enables SHALL be: byte = 0001 shifted left by addr[1:0]; half = 0011 (addr[1]=0) or 1100 (addr[1]=1); word = 1111.
REQ-011 Store data SHALL be replicated: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-012 Loads SHALL select the addressed lane and extend it to 32 bits: sign-extend when req_unsigned=0, zero-extend when 1; word loads pass through.
REQ-013 An ACCESS cycle counter SHALL clear on entry; if TIMEOUT cycles elapse without mem_ack, the block SHALL drop mem_en and go to DONE with resp_err=1 and resp_rdata=0.
REQ-014 req_size=11 SHALL complete IDLE->DONE with resp_err=1 and SHALL NOT assert mem_en.
REQ-015 mem_ack outside ACCESS SHALL be ignored.
REQ-016 A store response SHALL have resp_rdata=0 and resp_err=0.

Reset
REQ-017 rst=1 SHALL force state IDLE, clear the counter and latches, and set req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0 and mem_wdata=0.
REQ-018 rst during ACCESS or DONE SHALL abort the access with no response pulse; mem_en SHALL be 0 from the next edge.

Configuration
REQ-019 With macro LSU_MISALIGN_TRAP_EN defined, a misaligned request (half with addr[0]=1, or word with addr[1:0]!=0) SHALL go IDLE->DONE with resp_err=1 and no mem_en.
REQ-020 Without LSU_MISALIGN_TRAP_EN, a misaligned request SHALL proceed with the offending low address bits treated as 0 and resp_err=0.

Verification
REQ-021 Word store: addr 0x10010004, wdata 0xDEADBEEF, mem_ack in the first ACCESS cycle -> mem_addr 0x10010004, mem_be 1111, resp_valid two cycles after accept, resp_err=0.
REQ-022 Byte loads: addr 0x10010002, mem_rdata 0x12F45678 -> resp_rdata 0xFFFFFFF4 when signed, 0x000000F4 when unsigned, mem_be 0100.
REQ-023 Half store: addr 0x10010002, wdata 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD.
REQ-024 No mem_ack, TIMEOUT=16 -> mem_en high for 16 cycles, then resp_valid with resp_err=1 and resp_rdata=0.
REQ-025 Word load at addr 0x10010001 -> with LSU_MISALIGN_TRAP_EN, resp_err=1 and mem_en never set; without it, mem_addr 0x10010000 and resp_err=0.
REQ-026 rst asserted in the 3rd ACCESS cycle of a stalled load -> no resp_valid, mem_en=0 next cycle, and req_ready=1 in the first cycle after rst drops.
